// File: rtl/hexplay_pkg.sv
// rtl/hexplay_pkg.sv - shared widths, digit types and scan-order helper for hexplay_capture
package hexplay_pkg;

  localparam int DIGITS  = 8;
  localparam int AN_W    = 3;
  localparam int NIB_W   = 4;
  localparam int FRAME_W = 32;

  typedef logic [AN_W-1:0]  an_t;
  typedef logic [NIB_W-1:0] nib_t;

  typedef struct packed {
    an_t  an;
    nib_t nib;
  } digit_t;

  // The 3-bit add wraps 7 -> 0, which is exactly the scan order modulo 8.
  function automatic an_t next_idx(input an_t a);
    return a + an_t'(1);
  endfunction

endpackage

// File: rtl/hexplay_capture_if.sv
// rtl/hexplay_capture_if.sv - scan bus inputs and reconstructed frame outputs of hexplay_capture
interface hexplay_capture_if;
  import hexplay_pkg::*;

  logic [AN_W-1:0]    hexplay_an;
  logic [NIB_W-1:0]   hexplay_data;
  logic [FRAME_W-1:0] frame_data;
  logic               frame_valid;
  logic [DIGITS-1:0]  digit_mask;
  logic               seq_err;
  logic               stalled;

  modport master (
    output hexplay_an, hexplay_data,
    input  frame_data, frame_valid, digit_mask, seq_err, stalled
  );

  modport slave (
    input  hexplay_an, hexplay_data,
    output frame_data, frame_valid, digit_mask, seq_err, stalled
  );

endinterface

// File: rtl/hexplay_settle.sv
// rtl/hexplay_settle.sv - synchronizer plus settle filter producing one capture per stable bus period
module hexplay_settle
  import hexplay_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4
) (
  input  logic   clk,
  input  logic   rstn,
  input  digit_t raw,
  output logic   capture,
  output digit_t cap
);

  localparam int CW = $clog2(SETTLE_CYC + 1);

  logic [SYNC_STAGES-1:0][$bits(digit_t)-1:0] sync_q;
  digit_t        s;
  digit_t        s_prev;
  logic [CW-1:0] cnt;

  assign s = digit_t'(sync_q[SYNC_STAGES-1]);

  // The counter resets saturated so the idle 0/0 bus seen after reset never looks like a new digit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      s_prev <= '0;
      cnt    <= CW'(SETTLE_CYC);
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      s_prev <= s;
      if (s != s_prev) begin
        cnt <= '0;
      end else if (cnt != CW'(SETTLE_CYC)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign capture = (s == s_prev) && (cnt == CW'(SETTLE_CYC - 1));
  assign cap     = s;

endmodule

// File: rtl/hexplay_capture.sv
// rtl/hexplay_capture.sv - rebuilds 32-bit frames from the multiplexed hex-display scan bus
module hexplay_capture
  import hexplay_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              CLK100MHZ,
  input  logic              rstn,
  hexplay_capture_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic               capture;
  digit_t             cap;
  logic [FRAME_W-1:0] shadow;
  logic [FRAME_W-1:0] shadow_upd;
  logic [FRAME_W-1:0] frame_q;
  logic [DIGITS-1:0]  mask_q;
  logic [DIGITS-1:0]  mask_upd;
  logic [DIGITS-1:0]  sel;
  logic               fv_q;
  logic               se_q;
  logic               stall_q;
  logic               have_prev;
  logic               in_order;
  logic               frame_done;
  an_t                prev_an;
  logic [TW-1:0]      tcnt;

  hexplay_settle #(
    .SYNC_STAGES (SYNC_STAGES),
    .SETTLE_CYC  (SETTLE_CYC)
  ) u_settle (
    .clk     (CLK100MHZ),
    .rstn    (rstn),
    .raw     (digit_t'({bus.hexplay_an, bus.hexplay_data})),
    .capture (capture),
    .cap     (cap)
  );

  always_comb begin
    sel          = '0;
    sel[cap.an]  = 1'b1;
    shadow_upd   = shadow;
    shadow_upd[cap.an*NIB_W +: NIB_W] = cap.nib;
    in_order     = !have_prev || (cap.an == prev_an) || (cap.an == next_idx(prev_an));
    mask_upd     = in_order ? (mask_q | sel) : sel;
    frame_done   = in_order && (cap.an == an_t'(DIGITS - 1)) && (&mask_upd);
  end

  // A capture and the timeout can land on the same edge; the capture branch takes priority.
  always_ff @(posedge CLK100MHZ or negedge rstn) begin
    if (!rstn) begin
      shadow    <= '0;
      frame_q   <= '0;
      mask_q    <= '0;
      fv_q      <= 1'b0;
      se_q      <= 1'b0;
      stall_q   <= 1'b0;
      have_prev <= 1'b0;
      prev_an   <= '0;
      tcnt      <= '0;
    end else begin
      fv_q <= 1'b0;
      se_q <= 1'b0;
      if (capture) begin
        shadow    <= shadow_upd;
        prev_an   <= cap.an;
        have_prev <= 1'b1;
        tcnt      <= '0;
        stall_q   <= 1'b0;
        se_q      <= !in_order;
        if (frame_done) begin
          frame_q <= shadow_upd;
          fv_q    <= 1'b1;
          mask_q  <= '0;
        end else begin
          mask_q  <= mask_upd;
        end
      end else if (tcnt != TW'(TIMEOUT_CYC)) begin
        tcnt <= tcnt + TW'(1);
        if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
          stall_q   <= 1'b1;
          mask_q    <= '0;
          have_prev <= 1'b0;
        end
      end
    end
  end

  assign bus.frame_data  = frame_q;
  assign bus.frame_valid = fv_q;
  assign bus.digit_mask  = mask_q;
  assign bus.seq_err     = se_q;
  assign bus.stalled     = stall_q;

endmodule
